// File: rtl/decode.sv
// rtl/decode.sv - Y86-64 SEQ decode/write-back stage with 15x64 register file
//
// Ports:
//   clk    in   1  clock, all state updates on rising edge
//   reset  in   1  synchronous active-high reset, loads reg[i] = i
//   icode  in   4  instruction code
//   rA     in   4  register specifier A
//   rB     in   4  register specifier B
//   cnd    in   1  condition result, qualifies cmovXX write-back
//   valE   in  64  write-back data for port E
//   valM   in  64  write-back data for port M
//   valA   out 64  operand A (combinational read)
//   valB   out 64  operand B (combinational read)

module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [63:0] valA,
    output logic [63:0] valB
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    logic [63:0] regs_q [0:14];
    logic [63:0] regs_d [0:14];

    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;

        case (icode)
            4'h2, 4'h4, 4'h6, 4'hA: src_a = rA;
            4'h9, 4'hB:             src_a = RRSP;
            default:                src_a = RNONE;
        endcase

        case (icode)
            4'h4, 4'h5, 4'h6:       src_b = rB;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = RRSP;
            default:                src_b = RNONE;
        endcase

        case (icode)
            4'h2:                   dst_e = cnd ? rB : RNONE;
            4'h3, 4'h6:             dst_e = rB;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = RRSP;
            default:                dst_e = RNONE;
        endcase

        case (icode)
            4'h5, 4'hB:             dst_m = rA;
            default:                dst_m = RNONE;
        endcase
    end

    // Read muxes: ID F never matches an entry, so it reads as zero.
    always_comb begin
        valA = 64'd0;
        valB = 64'd0;
        for (int i = 0; i < 15; i++) begin
            if (src_a == 4'(i)) valA = regs_q[i];
            if (src_b == 4'(i)) valB = regs_q[i];
        end
    end

    // Port M is applied after port E so it wins when both target one register.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            regs_d[i] = regs_q[i];
            if (dst_e == 4'(i)) regs_d[i] = valE;
            if (dst_m == 4'(i)) regs_d[i] = valM;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 15; i++) begin
            if (reset) begin
                regs_q[i] <= 64'(i);
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - self-checking bench for decode

module tb_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic [3:0]  rA = 4'hF;
    logic [3:0]  rB = 4'hF;
    logic        cnd = 1'b0;
    logic [63:0] valE = 64'd0;
    logic [63:0] valM = 64'd0;
    logic [63:0] valA;
    logic [63:0] valB;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    logic [63:0] model [15];

    decode dut (
        .clk   (clk),
        .reset (reset),
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cnd   (cnd),
        .valE  (valE),
        .valM  (valM),
        .valA  (valA),
        .valB  (valB)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_src_a(logic [3:0] ic, logic [3:0] a);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_src_b(logic [3:0] ic, logic [3:0] b);
        if (ic inside {4'h4, 4'h5, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_e(logic [3:0] ic, logic [3:0] b, logic c);
        if ((ic == 4'h2 && c) || ic == 4'h3 || ic == 4'h6) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_m(logic [3:0] ic, logic [3:0] a);
        if (ic inside {4'h5, 4'hB}) return a;
        return 4'hF;
    endfunction

    function automatic logic [63:0] m_read(logic [3:0] id);
        if (id == 4'hF) return 64'd0;
        return model[id];
    endfunction

    // Reference state advances on the same edge as the DUT.
    always @(posedge clk) begin
        logic [3:0] de, dm;
        if (reset) begin
            for (int i = 0; i < 15; i++) model[i] = 64'(i);
            started = 1'b1;
        end else if (started) begin
            de = m_dst_e(icode, rB, cnd);
            dm = m_dst_m(icode, rA);
            if (de != 4'hF) model[de] = valE;
            if (dm != 4'hF) model[dm] = valM;
        end
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            tests++;
            if (valA !== m_read(m_src_a(icode, rA))) begin
                fails++;
                $display("FAIL model_valA t=%0t ic=%h got %h exp %h", $time, icode, valA,
                         m_read(m_src_a(icode, rA)));
            end
            tests++;
            if (valB !== m_read(m_src_b(icode, rB))) begin
                fails++;
                $display("FAIL model_valB t=%0t ic=%h got %h exp %h", $time, icode, valB,
                         m_read(m_src_b(icode, rB)));
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] e, input logic [63:0] m);
        icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Read two registers through rmmovq, which has no destinations.
    task automatic peek(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic [63:0] ea, input logic [63:0] eb);
        drive(4'h4, a, b, 1'b0, 64'd0, 64'd0);
        check({name, "_A"}, valA, ea);
        check({name, "_B"}, valB, eb);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();
        peek("reset_r0_r14", 4'h0, 4'hE, 64'd0, 64'd14);
        peek("reset_r4_r9", 4'h4, 4'h9, 64'd4, 64'd9);

        // cmov with cnd=0: reads rA only, no write
        drive(4'h2, 4'h1, 4'h2, 1'b0, 64'd99, 64'd0);
        check("cmov0_valA", valA, 64'd1);
        check("cmov0_valB", valB, 64'd0);
        tick();
        peek("cmov0_r2", 4'h2, 4'hF, 64'd2, 64'd0);

        do_reset();
        peek("rmmov_r2_r3", 4'h2, 4'h3, 64'd2, 64'd3);
        peek("rmmov_nochange", 4'h2, 4'h3, 64'd2, 64'd3);

        // irmovq
        do_reset();
        drive(4'h3, 4'hF, 4'h1, 1'b0, 64'd77, 64'd0);
        check("irmov_valA", valA, 64'd0);
        check("irmov_valB", valB, 64'd0);
        tick();
        peek("irmov_r1", 4'h1, 4'h3, 64'd77, 64'd3);

        // cmov cnd=1 then cnd=0
        drive(4'h2, 4'h3, 4'h5, 1'b1, 64'h1234, 64'd0);
        tick();
        peek("cmov1_r5", 4'h5, 4'hF, 64'h1234, 64'd0);
        drive(4'h2, 4'h3, 4'h5, 1'b0, 64'hAAAA, 64'd0);
        tick();
        peek("cmov0_r5", 4'h5, 4'hF, 64'h1234, 64'd0);

        // popq %rsp: M beats E
        do_reset();
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd12, 64'd500);
        check("popq_valA", valA, 64'd4);
        check("popq_valB", valB, 64'd4);
        tick();
        peek("popq_rsp", 4'h4, 4'hF, 64'd500, 64'd0);

        // mrmovq to r14, pushq, unlisted icode
        drive(4'h5, 4'hE, 4'h7, 1'b0, 64'd0, 64'hCAFE);
        check("mrmov_valB", valB, 64'd7);
        tick();
        drive(4'hA, 4'hE, 4'hF, 1'b0, 64'd492, 64'd0);
        check("pushq_valA", valA, 64'hCAFE);
        check("pushq_valB", valB, 64'd500);
        tick();
        drive(4'hC, 4'h1, 4'h2, 1'b1, 64'd1, 64'd2);
        check("icC_valA", valA, 64'd0);
        check("icC_valB", valB, 64'd0);
        tick();
        peek("push_r4_r14", 4'h4, 4'hE, 64'd492, 64'hCAFE);

        // reset overrides pending write-back
        drive(4'h3, 4'hF, 4'h7, 1'b0, 64'hDEAD, 64'd0);
        tick();
        peek("pre_rst_r7", 4'h7, 4'hF, 64'hDEAD, 64'd0);
        reset = 1'b1;
        drive(4'h6, 4'h7, 4'h7, 1'b0, 64'hBEEF, 64'd0);
        tick();
        reset = 1'b0;
        peek("rst_mid_r7_r14", 4'h7, 4'hE, 64'd7, 64'd14);
        peek("rst_mid_r4_r5", 4'h4, 4'h5, 64'd4, 64'd5);

        // directed sweep over all icodes, checked by the model each cycle
        for (int i = 0; i < 48; i++) begin
            drive(4'(i % 16), 4'((i * 7) % 16), 4'((i * 5 + 3) % 16), i[0],
                  64'(1000 + i), 64'(2000 + i));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Decode/write-back stage of the Y86-64 sequential (SEQ) processor.
- Owns the 15-entry × 64-bit program register file.
- From icode, rA and rB it selects source registers and drives valA and valB combinationally.
- On each rising clock edge it writes back valE and valM to destination registers chosen from icode, rA, rB and the condition flag cnd.

Parameters:
- None. Fixed widths: 64-bit data, 4-bit register IDs, 15 registers (IDs 0..14). ID 4'hF means "no register".

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- icode  input  4  instruction code of the current instruction
- rA  input  4  register specifier A
- rB  input  4  register specifier B
- cnd  input  1  condition result from execute; qualifies cmovXX write-back
- valE  input  64  execute-stage result for write-back port E
- valM  input  64  memory-stage result for write-back port M
- valA  output  64  operand A read from the register file
- valB  output  64  operand B read from the register file

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high (`reset`).
- Register file: reg[0..14], 64 bits each. rsp = ID 4.
- On a rising edge with reset=1, reg[i] <= i for i=0..14 (reg0=0, reg1=1, ... reg14=14). No write-back occurs in that cycle.
- Source select (combinational):
  - srcA = rA for icode 2 (cmov/rrmovq), 4 (rmmovq), 6 (OPq), A (pushq); 4 for icode 9 (ret), B (popq); otherwise F.
  - srcB = rB for icode 4, 5 (mrmovq), 6; 4 for icode 8 (call), 9, A, B; otherwise F.
- Read (combinational, zero latency):
  - valA = reg[srcA]; valB = reg[srcB].
  - A source of F, or any unused ID ≥ 15, reads as 64'd0.
  - Reads return pre-edge contents. There is no bypass of same-cycle writes.
- Destination select:
  - dstE = rB for icode 2 when cnd=1, and for icode 3 (irmovq) and 6.
  - dstE = 4 for icode 8, 9, A, B.
  - dstE = F otherwise, including icode 2 with cnd=0.
  - dstM = rA for icode 5 and B; F otherwise.
- Write-back, on a rising edge with reset=0:
  - If dstE≠F: reg[dstE] <= valE.
  - If dstM≠F: reg[dstM] <= valM.
  - If dstE==dstM (e.g. popq %rsp), valM wins.
  - Writes to ID F are ignored.
- Unlisted icodes (0 halt, 1 nop, 7 jXX, C..F): no sources, no destinations; valA=valB=0 and no state change.
- Reset asserted mid-program overrides any pending write-back in that cycle.
- Outputs are not registered. Before the first reset the register contents are undefined; benches must apply reset first.

Test Plan:
- Reset, then icode=2, rA=1, rB=2, cnd=0 -> valA=1, valB=0. After the edge with valE=99, reg2 is still 2 (cnd=0 suppresses the write).
- After reset, icode=4, rA=2, rB=3 -> valA=2, valB=3. An edge leaves all registers unchanged.
- After reset, icode=3, rA=F, rB=1, valE=77, edge -> reg1=77. Then icode=4, rA=1, rB=3 reads valA=77, valB=3. During the irmovq, valA=valB=0.
- icode=2, rA=3, rB=5, cnd=1, valE=0x1234, edge -> reg5=0x1234. Same with cnd=0 and valE=0xAAAA -> reg5 stays 0x1234.
- After reset, icode=B (popq), rA=4, valE=12, valM=500: before the edge valA=4, valB=4 (both rsp); after the edge rsp=500 (M beats E).
- Write a register, assert reset on the next edge while a write-back is pending -> all registers return to index values and the pending write is dropped.
